multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
Sequencing controller for the multi-cycle MIPS datapath variant: one shared instruction/data memory, one ALU, and IR/MDR/A/B/ALUOut holding registers.
- Moore FSM; steps each instruction through fetch, decode, execute, memory and writeback.
- Drives every datapath mux select and write enable.
- Stalls on a variable-latency memory through a ready handshake.
- Sits beside the datapath top level and replaces the single-cycle decoder.

Parameters:
- ra_sel, 2'b10: reg_dst code that selects register $31 (jal).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- op_code  in  6  IR[31:26]; stable from S_DECODE onward
- funct  in  6  IR[5:0]
- alu_zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current read/write this cycle
- pc_en  out  1  PC load enable (unconditional or qualified branch)
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  IR load
- mdr_write  out  1  MDR load
- reg_write  out  1  register file write
- reg_dst  out  2  write-register select: 00 = rt, 01 = rd, 10 = $31
- mem_to_reg  out  2  write-data select: 00 = ALUOut, 01 = MDR, 10 = PC
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = A
- alu_src_b  out  2  ALU B select: 00 = B, 01 = 4, 10 = ext imm, 11 = ext imm<<2
- alu_op  out  2  00 = add, 01 = sub, 10 = funct, 11 = opcode-immediate
- arith  out  1  immediate extension: 1 = sign-extend, 0 = zero-extend
- pc_source  out  2  PC input select: 00 = ALU, 01 = ALUOut, 10 = jump target, 11 = rs
- trap  out  1  illegal opcode seen; sticky until reset
- state  out  4  current state, for debug

Behaviour:
- Reset: rst_n low forces state = S_IDLE immediately, asynchronously, including mid-instruction. In S_IDLE every output is 0 (trap = 0, state = 0). S_IDLE goes to S_FETCH on the first clock after release.
- Outputs are combinational from the registered state, qualified by mem_ready and alu_zero where noted. Any output not listed for a state is 0.
- S_FETCH:
  - mem_read = 1, i_or_d = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 00, pc_source = 00.
  - ir_write and pc_en are asserted only in the cycle mem_ready = 1; that same edge moves to S_DECODE.
  - Otherwise hold in S_FETCH with the request steady.
- S_DECODE: alu_src_a = 0, alu_src_b = 11, alu_op = 00, arith = 1 (branch target to ALUOut). Dispatch on op_code:
  - 0x00 with funct 0x08 goes to S_JR; other 0x00 goes to S_EXEC.
  - 0x23 or 0x2B goes to S_MEM_ADDR.
  - 0x04 or 0x05 goes to S_BRANCH.
  - 0x02 goes to S_JUMP; 0x03 goes to S_JAL.
  - 0x08, 0x0A, 0x0C, 0x0D go to S_IMM_EXEC.
  - Any other opcode goes to S_TRAP.
- S_MEM_ADDR: alu_src_a = 1, alu_src_b = 10, arith = 1, alu_op = 00. Next is S_MEM_RD for lw, S_MEM_WR for sw.
- S_MEM_RD: mem_read = 1, i_or_d = 1. mdr_write asserted when mem_ready = 1; that edge moves to S_MEM_WB. Otherwise hold.
- S_MEM_WB: reg_write = 1, reg_dst = 00, mem_to_reg = 01. Next S_FETCH.
- S_MEM_WR: mem_write = 1, i_or_d = 1. Hold until mem_ready = 1, then S_FETCH.
- S_EXEC: alu_src_a = 1, alu_src_b = 00, alu_op = 10. Next S_R_WB.
- S_R_WB: reg_write = 1, reg_dst = 01, mem_to_reg = 00. Next S_FETCH.
- S_IMM_EXEC: alu_src_a = 1, alu_src_b = 10, alu_op = 11. arith = 0 for 0x0C/0x0D, otherwise 1. Next S_IMM_WB.
- S_IMM_WB: reg_write = 1, reg_dst = 00, mem_to_reg = 00. Next S_FETCH.
- S_BRANCH: alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_source = 01. pc_en = alu_zero for beq (0x04), pc_en = !alu_zero for bne (0x05). Next S_FETCH.
- S_JUMP: pc_source = 10, pc_en = 1. Next S_FETCH.
- S_JAL: pc_source = 10, pc_en = 1, reg_write = 1, reg_dst = ra_sel, mem_to_reg = 10 (PC already holds PC+4). Next S_FETCH.
- S_JR: pc_source = 11, pc_en = 1, reg_write = 0. Next S_FETCH.
- S_TRAP: trap = 1, all strobes 0. Absorbing until reset.
- mem_ready is ignored outside S_FETCH, S_MEM_RD and S_MEM_WR.
- Zero-wait memory cycle counts: lw 5; sw, R-type, immediate 4; beq, bne, j, jal, jr 3.
- Each wait cycle adds exactly 1, with all request outputs stable throughout the wait.

Decomposition:
- Package mc_pkg holds:
  - the 4-bit state encoding (S_IDLE = 0 ... S_TRAP = 14);
  - opcode and funct localparams;
  - mux select codes for alu_src_b, pc_source, mem_to_reg, reg_dst and alu_op.
- One sub-module, mc_next_state: pure combinational next-state function. The top module holds the state register and the output decode.

Test Plan:
- Reset release, mem_ready tied 1, op_code 0x00, funct 0x20 → states 0,1,2... sequence FETCH→DECODE→EXEC→R_WB→FETCH. reg_write = 1 only in R_WB, with reg_dst = 01.
- lw (0x23) with mem_ready low for 2 cycles in each of FETCH and MEM_RD → 9 cycles total. ir_write and mdr_write are each a single-cycle pulse coincident with mem_ready.
- beq with alu_zero = 1, then bne with alu_zero = 1 → pc_en = 1 in S_BRANCH for beq; pc_en = 0 for bne. Both take 3 cycles.
- jal (0x03) → S_JAL with pc_en = 1, reg_write = 1, reg_dst = 10, mem_to_reg = 10. jr (0x00, funct 0x08) → pc_source = 11, reg_write = 0.
- ori (0x0D) → arith = 0 in S_IMM_EXEC. addi (0x08) → arith = 1.
- Opcode 0x3F → trap = 1 from the next cycle and held for 20 cycles. Asserting rst_n low mid-S_MEM_WR → mem_write drops the same cycle, trap clears, state = 0.

Source files
------------

// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - state encoding, opcodes and mux select codes for the multi-cycle controller
package mc_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_MEM_WB   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_EXEC     = 4'd7,
        S_R_WB     = 4'd8,
        S_IMM_EXEC = 4'd9,
        S_IMM_WB   = 4'd10,
        S_BRANCH   = 4'd11,
        S_JUMP     = 4'd12,
        S_JAL      = 4'd13,
        S_TRAP     = 4'd14,
        S_JR       = 4'd15
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;

    localparam logic [1:0] ALU_B_REG    = 2'b00;
    localparam logic [1:0] ALU_B_FOUR   = 2'b01;
    localparam logic [1:0] ALU_B_IMM    = 2'b10;
    localparam logic [1:0] ALU_B_IMM_SH = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
    localparam logic [1:0] PC_SRC_RS     = 2'b11;

    localparam logic [1:0] WD_ALUOUT = 2'b00;
    localparam logic [1:0] WD_MDR    = 2'b01;
    localparam logic [1:0] WD_PC     = 2'b10;

    localparam logic [1:0] REG_DST_RT = 2'b00;
    localparam logic [1:0] REG_DST_RD = 2'b01;
    localparam logic [1:0] REG_DST_RA = 2'b10;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;
    localparam logic [1:0] ALU_OP_IMM   = 2'b11;

    function automatic logic is_imm_op(input logic [5:0] op);
        return (op == OP_ADDI) || (op == OP_SLTI) || (op == OP_ANDI) || (op == OP_ORI);
    endfunction

endpackage

// File: rtl/mc_next_state.sv
// rtl/mc_next_state.sv - combinational next-state function of the multi-cycle controller
module mc_next_state
    import mc_pkg::*;
(
    input  state_e     state,
    input  logic [5:0] op_code,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output state_e     next_state
);

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   next_state = S_FETCH;
            S_FETCH:  if (mem_ready) next_state = S_DECODE;
            S_DECODE: begin
                if (op_code == OP_RTYPE)
                    next_state = (funct == FN_JR) ? S_JR : S_EXEC;
                else if (op_code == OP_LW || op_code == OP_SW)
                    next_state = S_MEM_ADDR;
                else if (op_code == OP_BEQ || op_code == OP_BNE)
                    next_state = S_BRANCH;
                else if (op_code == OP_J)
                    next_state = S_JUMP;
                else if (op_code == OP_JAL)
                    next_state = S_JAL;
                else if (is_imm_op(op_code))
                    next_state = S_IMM_EXEC;
                else
                    next_state = S_TRAP;
            end
            S_MEM_ADDR: next_state = (op_code == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (mem_ready) next_state = S_MEM_WB;
            S_MEM_WR:   if (mem_ready) next_state = S_FETCH;
            S_EXEC:     next_state = S_R_WB;
            S_IMM_EXEC: next_state = S_IMM_WB;
            S_MEM_WB, S_R_WB, S_IMM_WB, S_BRANCH, S_JUMP, S_JAL, S_JR:
                        next_state = S_FETCH;
            S_TRAP:     next_state = S_TRAP;
            default:    next_state = S_IDLE;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - Moore sequencing controller for the multi-cycle MIPS datapath
module multicycle_control
    import mc_pkg::*;
#(
    parameter logic [1:0] ra_sel = REG_DST_RA
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op_code,
    input  logic [5:0] funct,
    input  logic       alu_zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mdr_write,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       arith,
    output logic [1:0] pc_source,
    output logic       trap,
    output logic [3:0] state
);

    state_e state_q;
    state_e state_d;

    mc_next_state u_next_state (
        .state      (state_q),
        .op_code    (op_code),
        .funct      (funct),
        .mem_ready  (mem_ready),
        .next_state (state_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    assign state = state_q;

    // Outputs decode straight from the registered state so reset clears them
    // without waiting for an edge; only handshake strobes look at inputs.
    always_comb begin
        pc_en      = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        mdr_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = REG_DST_RT;
        mem_to_reg = WD_ALUOUT;
        alu_src_a  = 1'b0;
        alu_src_b  = ALU_B_REG;
        alu_op     = ALU_OP_ADD;
        arith      = 1'b0;
        pc_source  = PC_SRC_ALU;
        trap       = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = ALU_B_FOUR;
                ir_write  = mem_ready;
                pc_en     = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = ALU_B_IMM_SH;
                arith     = 1'b1;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = ALU_B_IMM;
                arith     = 1'b1;
            end
            S_MEM_RD: begin
                mem_read  = 1'b1;
                i_or_d    = 1'b1;
                mdr_write = mem_ready;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = WD_MDR;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_OP_FUNCT;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = REG_DST_RD;
            end
            S_IMM_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = ALU_B_IMM;
                alu_op    = ALU_OP_IMM;
                arith     = !(op_code == OP_ANDI || op_code == OP_ORI);
            end
            S_IMM_WB: reg_write = 1'b1;
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_OP_SUB;
                pc_source = PC_SRC_ALUOUT;
                pc_en     = (op_code == OP_BNE) ? !alu_zero : alu_zero;
            end
            S_JUMP: begin
                pc_source = PC_SRC_JUMP;
                pc_en     = 1'b1;
            end
            S_JAL: begin
                pc_source  = PC_SRC_JUMP;
                pc_en      = 1'b1;
                reg_write  = 1'b1;
                reg_dst    = ra_sel;
                mem_to_reg = WD_PC;
            end
            S_JR: begin
                pc_source = PC_SRC_RS;
                pc_en     = 1'b1;
            end
            S_TRAP:  trap = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - randomized lockstep bench for multicycle_control
module tb_multicycle_control;

    localparam int ST_FETCH = 1, ST_DECODE = 2, ST_MEM_ADDR = 3, ST_MEM_RD = 4,
                   ST_MEM_WB = 5, ST_MEM_WR = 6, ST_EXEC = 7, ST_R_WB = 8,
                   ST_IMM_EXEC = 9, ST_IMM_WB = 10, ST_BRANCH = 11, ST_JUMP = 12,
                   ST_JAL = 13, ST_TRAP = 14, ST_JR = 15;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] op_code = 6'h0, funct = 6'h0;
    logic       alu_zero = 1'b0, mem_ready = 1'b0;
    logic       pc_en, i_or_d, mem_read, mem_write, ir_write, mdr_write, reg_write;
    logic [1:0] reg_dst, mem_to_reg, alu_src_b, alu_op, pc_source;
    logic       alu_src_a, arith, trap;
    logic [3:0] state;

    multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .op_code(op_code), .funct(funct),
        .alu_zero(alu_zero), .mem_ready(mem_ready), .pc_en(pc_en), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mdr_write(mdr_write), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .arith(arith), .pc_source(pc_source), .trap(trap), .state(state)
    );

    always #5 clk = ~clk;

    // Bit map: pe23 iod22 mr21 mw20 irw19 mdw18 rw17 rd16:15 mtr14:13 asa12 asb11:10 aop9:8 ar7 ps6:5 tr4 st3:0
    wire [23:0] act = {pc_en, i_or_d, mem_read, mem_write, ir_write, mdr_write, reg_write,
                       reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, arith,
                       pc_source, trap, state};

    int n_checks = 0, n_pass = 0;
    logic [5:0] cur_op = 6'h0, cur_fn = 6'h0;
    logic [23:0] hist[$];

    function automatic logic [23:0] model(input int st, input logic [5:0] op,
                                          input logic rdy, input logic z);
        logic pe, iod, mr, mw, irw, mdw, rw, asa, ar, tr;
        logic [1:0] rd, mtr, asb, aop, ps;
        {pe, iod, mr, mw, irw, mdw, rw, asa, ar, tr} = '0;
        {rd, mtr, asb, aop, ps} = '0;
        case (st)
            ST_FETCH:    begin mr = 1; asb = 2'b01; irw = rdy; pe = rdy; end
            ST_DECODE:   begin asb = 2'b11; ar = 1; end
            ST_MEM_ADDR: begin asa = 1; asb = 2'b10; ar = 1; end
            ST_MEM_RD:   begin mr = 1; iod = 1; mdw = rdy; end
            ST_MEM_WB:   begin rw = 1; mtr = 2'b01; end
            ST_MEM_WR:   begin mw = 1; iod = 1; end
            ST_EXEC:     begin asa = 1; aop = 2'b10; end
            ST_R_WB:     begin rw = 1; rd = 2'b01; end
            ST_IMM_EXEC: begin asa = 1; asb = 2'b10; aop = 2'b11; ar = !(op == 6'h0C || op == 6'h0D); end
            ST_IMM_WB:   rw = 1;
            ST_BRANCH:   begin asa = 1; aop = 2'b01; ps = 2'b01; pe = (op == 6'h04) ? z : !z; end
            ST_JUMP:     begin ps = 2'b10; pe = 1; end
            ST_JAL:      begin ps = 2'b10; pe = 1; rw = 1; rd = 2'b10; mtr = 2'b10; end
            ST_JR:       begin ps = 2'b11; pe = 1; end
            ST_TRAP:     tr = 1;
            default:     ;
        endcase
        return {pe, iod, mr, mw, irw, mdw, rw, rd, mtr, asa, asb, aop, ar, ps, tr, 4'(st)};
    endfunction

    task automatic check(input string name, input logic [23:0] a, input logic [23:0] e);
        n_checks++;
        if (a === e) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, a, e);
    endtask

    // Called at posedge+1; drives one cycle, checks at negedge, returns at next posedge+1.
    task automatic step(input int st, input logic rdy, input int z);
        mem_ready = rdy;
        alu_zero  = (z == 2) ? 1'($urandom) : z[0];
        op_code   = (st == ST_FETCH) ? 6'($urandom) : cur_op;
        funct     = (st == ST_FETCH) ? 6'($urandom) : cur_fn;
        @(negedge clk);
        check($sformatf("cycle st%0d op%h", st, cur_op), act, model(st, cur_op, rdy, alu_zero));
        hist.push_back(act);
        @(posedge clk); #1;
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int fw, input int mwt, input int z);
        cur_op = op; cur_fn = fn;
        hist.delete();
        for (int i = 0; i < fw; i++) step(ST_FETCH, 1'b0, z);
        step(ST_FETCH, 1'b1, z);
        step(ST_DECODE, 1'($urandom), z);
        if (op == 6'h00 && fn == 6'h08) step(ST_JR, 1'($urandom), z);
        else if (op == 6'h00) begin
            step(ST_EXEC, 1'($urandom), z);
            step(ST_R_WB, 1'($urandom), z);
        end else if (op == 6'h23) begin
            step(ST_MEM_ADDR, 1'($urandom), z);
            for (int i = 0; i < mwt; i++) step(ST_MEM_RD, 1'b0, z);
            step(ST_MEM_RD, 1'b1, z);
            step(ST_MEM_WB, 1'($urandom), z);
        end else if (op == 6'h2B) begin
            step(ST_MEM_ADDR, 1'($urandom), z);
            for (int i = 0; i < mwt; i++) step(ST_MEM_WR, 1'b0, z);
            step(ST_MEM_WR, 1'b1, z);
        end else if (op == 6'h04 || op == 6'h05) step(ST_BRANCH, 1'($urandom), z);
        else if (op == 6'h02) step(ST_JUMP, 1'($urandom), z);
        else if (op == 6'h03) step(ST_JAL, 1'($urandom), z);
        else begin
            step(ST_IMM_EXEC, 1'($urandom), z);
            step(ST_IMM_WB, 1'($urandom), z);
        end
    endtask

    // Enters with rst_n already low; leaves at posedge+1 with the DUT in fetch.
    task automatic release_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_held", act, 24'h0);
        rst_n = 1'b1;
        #1 check("idle_after_release", act, 24'h0);
        @(posedge clk); #1;
    endtask

    logic [5:0] ops[12] = '{6'h00, 6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03,
                            6'h08, 6'h0A, 6'h0C, 6'h0D};
    logic [5:0] r_fns[5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

    initial begin
        int cnt;
        logic [5:0] rop, rfn;
        int k;

        #1 check("reset_async", act, 24'h0);
        release_reset();

        // R-type add, zero waits: literal state walk and write-back fields
        run_instr(6'h00, 6'h20, 0, 0, 2);
        check("rtype_states", {8'h0, hist[0][3:0], hist[1][3:0], hist[2][3:0], hist[3][3:0]},
              24'h001278);
        check("rtype_rwb", {21'h0, hist[3][17], hist[3][16:15]}, 24'h000005);
        check("rtype_rw_only_wb", {21'h0, hist[0][17], hist[1][17], hist[2][17]}, 24'h0);

        // lw with two waits in fetch and in mem read: 9 cycles, one pulse each
        run_instr(6'h23, 6'h00, 2, 2, 2);
        check("lw_cycles", 24'(hist.size()), 24'd9);
        cnt = 0;
        foreach (hist[i]) cnt += int'(hist[i][19]) + int'(hist[i][18]) * 16;
        check("lw_pulses", 24'(cnt), 24'h11);
        check("lw_pulse_pos", {22'h0, hist[2][19], hist[7][18]}, 24'h3);

        run_instr(6'h04, 6'h00, 0, 0, 1);
        check("beq_taken", {20'h0, 2'(hist.size()), 1'b0, hist[2][23]}, 24'h00000D);
        run_instr(6'h05, 6'h00, 0, 0, 1);
        check("bne_not_taken", {20'h0, 2'(hist.size()), 1'b0, hist[2][23]}, 24'h00000C);

        run_instr(6'h03, 6'h00, 0, 0, 2);
        check("jal_fields", {18'h0, hist[2][23], hist[2][17], hist[2][16:15], hist[2][14:13]},
              24'h00003A);
        run_instr(6'h00, 6'h08, 0, 0, 2);
        check("jr_fields", {21'h0, hist[2][6:5], hist[2][17]}, 24'h000006);

        run_instr(6'h0D, 6'h00, 0, 0, 2);
        check("ori_zero_ext", {23'h0, hist[2][7]}, 24'h0);
        run_instr(6'h08, 6'h00, 0, 0, 2);
        check("addi_sign_ext", {23'h0, hist[2][7]}, 24'h1);

        for (int n = 0; n < 250; n++) begin
            k = int'($urandom_range(0, 11));
            rop = ops[k];
            rfn = (k == 1) ? 6'h08 : r_fns[$urandom_range(0, 4)];
            run_instr(rop, rfn, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 2);
        end

        // Illegal opcode: trap from the cycle after decode, absorbing
        cur_op = 6'h3F; cur_fn = 6'h00;
        step(ST_FETCH, 1'b1, 2);
        step(ST_DECODE, 1'b1, 2);
        for (int i = 0; i < 20; i++) step(ST_TRAP, 1'($urandom), 2);
        rst_n = 1'b0;
        #1 check("trap_cleared_by_reset", act, 24'h0);
        release_reset();

        // Reset while a store is waiting on memory
        cur_op = 6'h2B; cur_fn = 6'h00;
        step(ST_FETCH, 1'b1, 2);
        step(ST_DECODE, 1'b0, 2);
        step(ST_MEM_ADDR, 1'b0, 2);
        step(ST_MEM_WR, 1'b0, 2);
        mem_ready = 1'b0;
        #1 check("sw_waiting", {23'h0, mem_write}, 24'h1);
        rst_n = 1'b0;
        #1 check("sw_reset_async", act, 24'h0);
        release_reset();
        run_instr(6'h2B, 6'h00, 1, 1, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
